booth_seq_ctrl: RTL

- Iterative (one-step-per-clock) signed radix-2 Booth multiplier controller.
- Instantiates a single registered Booth step datapath and sequences it over WIDTH iterations.
- Replaces the unrolled combinational chain wherever area matters more than latency.
- Sits between a requester (start/ready handshake) and the consumer of the 2*WIDTH product.

---
 rtl/booth_pkg.sv | 24 ++
 rtl/booth_step.sv | 37 +++
 rtl/booth_seq_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_pkg
// Description : Shared state encoding, default width and counter sizing for
//               the sequential Booth multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

    localparam int c_default_width = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to hold the step index 0..width-1.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// ============================================================================
// Module      : booth_step
// Description : One combinational radix-2 Booth step: add/sub select on
//               (Q[0], q_1) followed by an arithmetic right shift of {A,Q,q_1}.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_q1,
    input  logic [WIDTH:0]   i_m,
    output logic [WIDTH:0]   o_a,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q1
);

    logic [WIDTH:0] w_sum;

    always_comb begin
        w_sum = i_a;
        unique case ({i_q[0], i_q1})
            2'b10:   w_sum = i_a - i_m;
            2'b01:   w_sum = i_a + i_m;
            default: w_sum = i_a;
        endcase
        o_a  = {w_sum[WIDTH], w_sum[WIDTH:1]};
        o_q  = {w_sum[0], i_q[WIDTH-1:1]};
        o_q1 = i_q[0];
    end

endmodule
`default_nettype wire

// File: rtl/booth_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : booth_seq_ctrl
// Description : Iterative signed radix-2 Booth multiplier, one step per clock.
//               Optional macro BOOTH_EARLY_TERM_EN enables early termination.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int             c_cw     = cnt_width(WIDTH);
    localparam int             c_last_i = WIDTH - 1;
    localparam logic [c_cw:0]  c_last   = c_last_i[c_cw:0];

    state_t               r_state, w_state_nxt;
    logic [WIDTH:0]       r_a, r_m;
    logic [WIDTH-1:0]     r_q;
    logic                 r_q1;
    logic [c_cw-1:0]      r_count;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH:0]       w_step_a;
    logic [WIDTH-1:0]     w_step_q;
    logic                 w_step_q1;
    logic                 w_finish;
    logic                 w_load_done;
    logic [2*WIDTH-1:0]   w_result;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .i_a  (r_a),
        .i_q  (r_q),
        .i_q1 (r_q1),
        .i_m  (r_m),
        .o_a  (w_step_a),
        .o_q  (w_step_q),
        .o_q1 (w_step_q1)
    );

`ifdef BOOTH_EARLY_TERM_EN
    logic [c_cw:0]               w_rem;
    logic                        w_uniform;
    logic signed [2*WIDTH:0]     w_aq_shift;

    // Once the unprocessed multiplier bits all match q_1 the remaining steps
    // are pure shifts, so they collapse into one arithmetic shift.
    always_comb begin
        w_rem     = c_last - {1'b0, r_count};
        w_uniform = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i < int'(w_rem)) && (w_step_q[i] != w_step_q1)) begin
                w_uniform = 1'b0;
            end
        end
        w_aq_shift = $signed({w_step_a, w_step_q}) >>> w_rem;
    end

    assign w_finish    = w_uniform;
    assign w_result    = w_aq_shift[2*WIDTH-1:0];
    assign w_load_done = (b == '0);
`else
    assign w_finish    = (r_count == c_last[c_cw-1:0]);
    assign w_result    = {w_step_a[WIDTH-1:0], w_step_q};
    assign w_load_done = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && start) begin
                r_m     <= {a[WIDTH-1], a};
                r_a     <= '0;
                r_q     <= b;
                r_q1    <= 1'b0;
                r_count <= '0;
                if (w_load_done) begin
                    r_product <= '0;
                end
            end else if (r_state == ST_RUN) begin
                r_a     <= w_step_a;
                r_q     <= w_step_q;
                r_q1    <= w_step_q1;
                r_count <= r_count + {{(c_cw-1){1'b0}}, 1'b1};
                if (w_finish) begin
                    r_product <= w_result;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_nxt = w_load_done ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_finish) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign product = r_product;

endmodule
`default_nettype wire
